fifo_wr_arbiter: RTL and testbench

//   Shares the write port of one 32-bit FIFO between NREQ producers.

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter that shares one FIFO write port between NREQ producers.
// Build option FIFO_ARB_PRIO_EN: producer 0 wins any idle arbitration it takes part in.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4,
   localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW       = $clog2(MAX_BURST) + 1
) (
   input  logic               clock,
   input  logic               sclr,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               fifo_full,
   output logic               fifo_wrreq,
   output logic [DW-1:0]      fifo_data,
   output logic [IW-1:0]      grant_id,
   output logic               busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_grant_id;
   logic [IW-1:0]   r_rr_ptr;
   logic [CW-1:0]   r_beat_cnt;

   state_t          w_state_next;
   logic [IW-1:0]   w_grant_next;
   logic [IW-1:0]   w_rr_next;
   logic [CW-1:0]   w_cnt_next;
   logic [NREQ-1:0] w_ready;
   logic            w_wrreq;
   logic            w_any_valid;
   logic            w_prio_hit;
   logic [IW-1:0]   w_winner;
   logic [IW-1:0]   w_cand [NREQ];

   function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] ptr, input int off);
      int sum;
      sum = int'(ptr) + off;
      return IW'(sum % NREQ);
   endfunction

   // Candidate gi is the index visited at step gi+1 of the scan starting after rr_ptr.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
         assign w_cand[gi] = rot_idx(r_rr_ptr, gi + 1);
      end
   endgenerate

   assign w_any_valid = |req_valid;

   always_comb begin
      w_winner   = '0;
      w_prio_hit = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[w_cand[k]]) begin
            w_winner = w_cand[k];
         end
      end
`ifdef FIFO_ARB_PRIO_EN
      if (req_valid[0]) begin
         w_winner   = '0;
         w_prio_hit = 1'b1;
      end
`endif
   end

   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant_id;
      w_rr_next    = r_rr_ptr;
      w_cnt_next   = r_beat_cnt;
      w_ready      = '0;
      w_wrreq      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_any_valid) begin
               w_state_next = S_BUSY;
               w_grant_next = w_winner;
               w_rr_next    = w_prio_hit ? r_rr_ptr : w_winner;
               w_cnt_next   = '0;
            end
         end
         S_BUSY: begin
            w_ready[r_grant_id] = ~fifo_full;
            w_wrreq             = req_valid[r_grant_id] & ~fifo_full;
            if (!req_valid[r_grant_id]) begin
               w_state_next = S_IDLE;
            end else if (w_wrreq) begin
               w_cnt_next = r_beat_cnt + 1'b1;
               if (r_beat_cnt == CW'(MAX_BURST - 1)) begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // A beat presented during reset is never handed to the FIFO; the producer re-sends it.
      if (sclr) begin
         w_ready = '0;
         w_wrreq = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         r_state    <= S_IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= IW'(NREQ - 1);
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_grant_id <= w_grant_next;
         r_rr_ptr   <= w_rr_next;
         r_beat_cnt <= w_cnt_next;
      end
   end

   assign req_ready  = w_ready;
   assign fifo_wrreq = w_wrreq;
   assign fifo_data  = req_data[r_grant_id*DW +: DW];
   assign grant_id   = r_grant_id;
   assign busy       = (r_state == S_BUSY);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=32, MAX_BURST=4); producers send {id, beat#}.
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int MB   = 4;

   logic              clock = 1'b0;
   logic              sclr;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              fifo_full;
   logic              fifo_wrreq;
   logic [DW-1:0]     fifo_data;
   logic [1:0]        grant_id;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int pcnt [NREQ];
   logic [DW-1:0] cap [$];

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
      .clock      (clock),
      .sclr       (sclr),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wrreq (fifo_wrreq),
      .fifo_data  (fifo_data),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (fifo_wrreq === 1'b1) cap.push_back(fifo_data);
   end

   function automatic logic [DW-1:0] word(input int p, input int beat);
      return {8'(p), 24'(beat)};
   endfunction

   task automatic set_data();
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word(i, pcnt[i]);
   endtask

   task automatic drive(input logic [NREQ-1:0] v, input logic f, input logic r);
      req_valid = v;
      fifo_full = f;
      sclr      = r;
      #1;
   endtask

   task automatic tick();
      logic [NREQ-1:0] acc;
      acc = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) pcnt[i]++;
      set_data();
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_cap(input string tag, input int p, input int base, input int n);
      chk({tag, "_count"}, 32'(cap.size()), 32'(n));
      for (int k = 0; k < n && k < cap.size(); k++) chk({tag, "_data"}, cap[k], word(p, base + k));
   endtask

   initial begin
      int base;
      int exp_g;
      for (int i = 0; i < NREQ; i++) pcnt[i] = 0;
      set_data();

      // 1: reset held two cycles with every producer valid
      drive(4'b1111, 1'b0, 1'b1);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
      end
      drive(4'b1111, 1'b0, 1'b0);
      cap.delete();
      chk("rel_idle_busy", 32'(busy), 32'd0);
      chk("rel_idle_wrreq", 32'(fifo_wrreq), 32'd0);
      tick();

      // 2: continuous requests, five grants of four beats with an idle cycle between
      for (int g = 0; g < 5; g++) begin
`ifdef FIFO_ARB_PRIO_EN
         exp_g = 0;
`else
         exp_g = g % NREQ;
`endif
         for (int b = 0; b < MB; b++) begin
            chk("rr_busy", 32'(busy), 32'd1);
            chk("rr_grant", 32'(grant_id), 32'(exp_g));
            chk("rr_wrreq", 32'(fifo_wrreq), 32'd1);
            tick();
         end
         if (g == 4) drive(4'b0000, 1'b0, 1'b0);
         chk("rr_gap_busy", 32'(busy), 32'd0);
         tick();
      end
      chk("rr_count", 32'(cap.size()), 32'd20);
      for (int k = 0; k < 20 && k < cap.size(); k++) begin
`ifdef FIFO_ARB_PRIO_EN
         chk("rr_data", cap[k], word(0, k));
`else
         chk("rr_data", cap[k], word((k / MB) % NREQ, (k % MB) + ((k >= 16) ? MB : 0)));
`endif
      end

      // 3: producer 2 ends its burst after two beats; pointer then favours producer 0
      base = pcnt[2];
      cap.delete();
      drive(4'b0100, 1'b0, 1'b0);
      tick();
      chk("early_grant", 32'(grant_id), 32'd2);
      chk("early_wr0", 32'(fifo_wrreq), 32'd1);
      tick();
      chk("early_wr1", 32'(fifo_wrreq), 32'd1);
      tick();
      drive(4'b0000, 1'b0, 1'b0);
      chk("early_drop_busy", 32'(busy), 32'd1);
      chk("early_drop_wrreq", 32'(fifo_wrreq), 32'd0);
      tick();
      chk("early_idle", 32'(busy), 32'd0);
      drive(4'b0101, 1'b0, 1'b0);
      tick();
      drive(4'b0000, 1'b0, 1'b0);
      chk("early_next_busy", 32'(busy), 32'd1);
      chk("early_next_grant", 32'(grant_id), 32'd0);
      tick();
      chk_cap("early", 2, base, 2);

      // 4: FIFO full for five cycles in the middle of producer 1's burst
      base = pcnt[1];
      cap.delete();
      drive(4'b0010, 1'b0, 1'b0);
      tick();
      chk("stall_grant", 32'(grant_id), 32'd1);
      chk("stall_wr_first", 32'(fifo_wrreq), 32'd1);
      tick();
      for (int c = 0; c < 5; c++) begin
         drive(4'b0010, 1'b1, 1'b0);
         chk("stall_wrreq", 32'(fifo_wrreq), 32'd0);
         chk("stall_ready", 32'(req_ready), 32'd0);
         chk("stall_busy", 32'(busy), 32'd1);
         chk("stall_hold", 32'(grant_id), 32'd1);
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         drive(4'b0010, 1'b0, 1'b0);
         chk("stall_resume_wr", 32'(fifo_wrreq), 32'd1);
         chk("stall_resume_rdy", 32'(req_ready), 32'b0010);
         tick();
      end
      chk("stall_end_busy", 32'(busy), 32'd0);
      chk("stall_end_ready", 32'(req_ready), 32'd0);
      drive(4'b0000, 1'b0, 1'b0);
      tick();
      chk_cap("stall", 1, base, MB);

      // 5: reset asserted on the second beat of producer 2's burst
      base = pcnt[2];
      cap.delete();
      drive(4'b0100, 1'b0, 1'b0);
      tick();
      chk("srst_grant", 32'(grant_id), 32'd2);
      tick();
      drive(4'b0100, 1'b0, 1'b1);
      chk("srst_wrreq", 32'(fifo_wrreq), 32'd0);
      chk("srst_ready", 32'(req_ready), 32'd0);
      tick();
      drive(4'b1011, 1'b0, 1'b0);
      chk("srst_after_busy", 32'(busy), 32'd0);
      tick();
      drive(4'b0000, 1'b0, 1'b0);
      chk("srst_next_busy", 32'(busy), 32'd1);
      chk("srst_next_grant", 32'(grant_id), 32'd0);
      tick();
      chk_cap("srst", 2, base, 1);

      // 6: pointer at 0 with producers 0 and 1 requesting
      drive(4'b0011, 1'b0, 1'b0);
      chk("prio_idle", 32'(busy), 32'd0);
      tick();
`ifdef FIFO_ARB_PRIO_EN
      exp_g = 0;
`else
      exp_g = 1;
`endif
      chk("prio_grant", 32'(grant_id), 32'(exp_g));
      chk("prio_data", fifo_data, word(exp_g, pcnt[exp_g]));
      drive(4'b0000, 1'b0, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
